// File: rtl/mips_cpu_harvard_core.sv
// Single-cycle MIPS-I subset core with separate instruction and data ports.
// One instruction retires per enabled clock. A branch delay slot is modelled by
// carrying the next PC alongside the current PC. The core halts when control
// reaches HALT_ADDR.
module mips_cpu_harvard_core #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    input  logic        clk_enable,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic [31:0] data_address,
    output logic        data_write,
    output logic        data_read,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03,
                           OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07,
                           OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
                           OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LW = 6'h23,
                           OP_SW = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04,
                           F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_JALR = 6'h09,
                           F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13,
                           F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25,
                           F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;

    // Instruction memory delivers little-endian bytes; decode wants big-endian fields.
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Declaration initialisers give the power-on state; reset restores the same values.
    logic [31:0] pc  = RESET_VECTOR;
    logic [31:0] npc = RESET_VECTOR + 32'd4;
    logic [31:0] hi  = 32'h0;
    logic [31:0] lo  = 32'h0;
    logic        run = 1'b1;
    logic [31:0] gpr [0:31] = '{default: 32'h0};

    logic [31:0]        instr, rs_val, rt_val, simm, zimm, pc_plus4, pc_plus8, br_target, j_target;
    logic signed [31:0] rs_s, rt_s, simm_s;
    logic [5:0]         opcode, funct;
    logic [4:0]         rs, rt, rd, shamt;
    logic [15:0]        imm16;
    logic [25:0]        idx26;

    assign instr     = byte_swap(instr_readdata);
    assign opcode    = instr[31:26];
    assign rs        = instr[25:21];
    assign rt        = instr[20:16];
    assign rd        = instr[15:11];
    assign shamt     = instr[10:6];
    assign funct     = instr[5:0];
    assign imm16     = instr[15:0];
    assign idx26     = instr[25:0];
    assign rs_val    = gpr[rs];
    assign rt_val    = gpr[rt];
    assign rs_s      = rs_val;
    assign rt_s      = rt_val;
    assign simm      = {{16{imm16[15]}}, imm16};
    assign simm_s    = simm;
    assign zimm      = {16'h0, imm16};
    assign pc_plus4  = pc + 32'd4;
    assign pc_plus8  = pc + 32'd8;
    assign br_target = pc_plus4 + {simm[29:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], idx26, 2'b00};

    logic        wr_en, taken, hi_wr, lo_wr, is_lw, is_sw;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data, target;

    // Decode and execute: register write-back, branch decision, HI/LO and memory strobes.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = rt;
        wr_data = 32'h0;
        taken   = 1'b0;
        target  = br_target;
        hi_wr   = 1'b0;
        lo_wr   = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                wr_addr = rd;
                case (funct)
                    F_SLL:  begin wr_en = 1'b1; wr_data = rt_val << shamt; end
                    F_SRL:  begin wr_en = 1'b1; wr_data = rt_val >> shamt; end
                    F_SRA:  begin wr_en = 1'b1; wr_data = rt_s >>> shamt; end
                    F_SLLV: begin wr_en = 1'b1; wr_data = rt_val << rs_val[4:0]; end
                    F_SRLV: begin wr_en = 1'b1; wr_data = rt_val >> rs_val[4:0]; end
                    F_SRAV: begin wr_en = 1'b1; wr_data = rt_s >>> rs_val[4:0]; end
                    F_JR:   begin taken = 1'b1; target = rs_val; end
                    F_JALR: begin taken = 1'b1; target = rs_val; wr_en = 1'b1; wr_data = pc_plus8; end
                    F_MFHI: begin wr_en = 1'b1; wr_data = hi; end
                    F_MTHI: hi_wr = 1'b1;
                    F_MFLO: begin wr_en = 1'b1; wr_data = lo; end
                    F_MTLO: lo_wr = 1'b1;
                    F_ADDU: begin wr_en = 1'b1; wr_data = rs_val + rt_val; end
                    F_SUBU: begin wr_en = 1'b1; wr_data = rs_val - rt_val; end
                    F_AND:  begin wr_en = 1'b1; wr_data = rs_val & rt_val; end
                    F_OR:   begin wr_en = 1'b1; wr_data = rs_val | rt_val; end
                    F_XOR:  begin wr_en = 1'b1; wr_data = rs_val ^ rt_val; end
                    F_NOR:  begin wr_en = 1'b1; wr_data = ~(rs_val | rt_val); end
                    F_SLT:  begin wr_en = 1'b1; wr_data = {31'h0, rs_s < rt_s}; end
                    F_SLTU: begin wr_en = 1'b1; wr_data = {31'h0, rs_val < rt_val}; end
                    default: ;
                endcase
            end
            OP_REGIMM: begin
                if (rt == 5'd0) taken = (rs_s < 32'sd0);
                else if (rt == 5'd1) taken = (rs_s >= 32'sd0);
            end
            OP_J:     begin taken = 1'b1; target = j_target; end
            OP_JAL:   begin taken = 1'b1; target = j_target; wr_en = 1'b1; wr_addr = 5'd31; wr_data = pc_plus8; end
            OP_BEQ:   taken = (rs_val == rt_val);
            OP_BNE:   taken = (rs_val != rt_val);
            OP_BLEZ:  taken = (rs_s <= 32'sd0);
            OP_BGTZ:  taken = (rs_s > 32'sd0);
            OP_ADDIU: begin wr_en = 1'b1; wr_data = rs_val + simm; end
            OP_SLTI:  begin wr_en = 1'b1; wr_data = {31'h0, rs_s < simm_s}; end
            OP_SLTIU: begin wr_en = 1'b1; wr_data = {31'h0, rs_val < simm}; end
            OP_ANDI:  begin wr_en = 1'b1; wr_data = rs_val & zimm; end
            OP_ORI:   begin wr_en = 1'b1; wr_data = rs_val | zimm; end
            OP_XORI:  begin wr_en = 1'b1; wr_data = rs_val ^ zimm; end
            OP_LUI:   begin wr_en = 1'b1; wr_data = {imm16, 16'h0}; end
            OP_LW:    begin wr_en = 1'b1; wr_data = data_readdata; is_lw = 1'b1; end
            OP_SW:    is_sw = 1'b1;
            default: ;
        endcase
    end

    assign active         = run;
    assign instr_address  = pc;
    assign register_v0    = gpr[2];
    assign data_address   = rs_val + simm;
    assign data_writedata = rt_val;
    assign data_read      = run & is_lw;
    assign data_write     = run & clk_enable & is_sw;

    // Control state: PC/next-PC delay-slot pair, halt detection, HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc  <= RESET_VECTOR;
            npc <= RESET_VECTOR + 32'd4;
            hi  <= 32'h0;
            lo  <= 32'h0;
            run <= 1'b1;
        end else if (clk_enable && run) begin
            if (npc == HALT_ADDR) begin
                pc  <= 32'h0;
                run <= 1'b0;
            end else begin
                pc <= npc;
            end
            npc <= taken ? target : npc + 32'd4;
            if (hi_wr) hi <= rs_val;
            if (lo_wr) lo <= rs_val;
        end
    end

    // Register file write-back; $0 is never written so it always reads zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) gpr[i] <= 32'h0;
        end else if (clk_enable && run && wr_en && wr_addr != 5'd0) begin
            gpr[wr_addr] <= wr_data;
        end
    end
endmodule

// File: tb/tb_mips_cpu_harvard_core.sv
// Directed bench for mips_cpu_harvard_core: small programs loaded into a model
// instruction memory, expected results queued on load and compared afterwards.
module tb_mips_cpu_harvard_core;
    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0, reset = 1'b0, clk_enable = 1'b1;
    logic        active, data_write, data_read;
    logic [31:0] register_v0, instr_address, instr_readdata;
    logic [31:0] data_address, data_writedata, data_readdata;

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:15] = '{default: 32'h0};
    logic [31:0] off;

    string       tag_q[$];
    logic [31:0] exp_q[$];
    int          errors = 0, checks = 0;
    int          wr_cnt = 0;
    logic [31:0] wr_addr = 32'hFFFFFFFF;

    mips_cpu_harvard_core dut (
        .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
        .clk_enable(clk_enable), .instr_address(instr_address),
        .instr_readdata(instr_readdata), .data_address(data_address),
        .data_write(data_write), .data_read(data_read),
        .data_writedata(data_writedata), .data_readdata(data_readdata)
    );

    always #5 clk = ~clk;

    // Instruction memory stores big-endian words and presents them little-endian.
    always_comb begin
        off = instr_address - RV;
        instr_readdata = 32'h0;
        if (off[31:8] == 24'h0 && off[1:0] == 2'b00)
            instr_readdata = {imem[off[7:2]][7:0], imem[off[7:2]][15:8],
                              imem[off[7:2]][23:16], imem[off[7:2]][31:24]};
    end

    assign data_readdata = dmem[data_address[5:2]];
    always @(posedge clk) if (data_write) dmem[data_address[5:2]] <= data_writedata;

    function automatic logic [31:0] r_op(input int rs, input int rt, input int rd, input int sh, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction
    function automatic logic [31:0] i_op(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] j_op(input int op, input logic [31:0] tgt);
        return {6'(op), tgt[27:2]};
    endfunction

    localparam logic [31:0] NOP    = 32'h0;
    localparam logic [31:0] JR_ZERO = 32'h00000008;

    task automatic expect_v(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic check_next(input logic [31:0] obs);
        string t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: got %h, want a queued value", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: got %h, want %h", t, obs, e);
            end
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = NOP;
    endtask

    task automatic load_lo_prog();
        clear_imem();
        imem[0] = i_op(9, 1, 1, 5);
        imem[1] = r_op(1, 0, 0, 0, 'h13);
        imem[2] = r_op(0, 0, 2, 0, 'h12);
        imem[3] = JR_ZERO;
        imem[4] = NOP;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        if (data_write) begin
            wr_cnt++;
            wr_addr = data_address;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_halt(input int maxc);
        for (int i = 0; i < maxc && active; i++) step();
    endtask

    initial begin
        #1;
        expect_v("poweron_pc", RV);
        expect_v("poweron_active", 32'd1);
        expect_v("poweron_v0", 32'd0);
        check_next(instr_address);
        check_next({31'h0, active});
        check_next(register_v0);

        // mtlo/mflo then jr $0 with a nop delay slot
        load_lo_prog();
        expect_v("lo_v0", 32'd5);
        expect_v("lo_active", 32'd0);
        expect_v("lo_iaddr", 32'd0);
        do_reset();
        run_halt(50);
        check_next(register_v0);
        check_next({31'h0, active});
        check_next(instr_address);

        // mthi/mfhi, delay slot overwrites $v0 with -1
        clear_imem();
        imem[0] = i_op(9, 1, 1, 5);
        imem[1] = r_op(1, 0, 0, 0, 'h11);
        imem[2] = r_op(0, 0, 2, 0, 'h10);
        imem[3] = JR_ZERO;
        imem[4] = i_op(9, 0, 2, -1);
        expect_v("hi_v0_mid", 32'd5);
        expect_v("hi_v0_final", 32'hFFFFFFFF);
        expect_v("hi_active", 32'd0);
        do_reset();
        repeat (3) step();
        check_next(register_v0);
        run_halt(50);
        check_next(register_v0);
        check_next({31'h0, active});

        // sw then lw through the data memory model
        clear_imem();
        imem[0] = i_op(9, 0, 1, 'h1234);
        imem[1] = i_op('h2B, 0, 1, 0);
        imem[2] = i_op('h23, 0, 2, 0);
        imem[3] = JR_ZERO;
        expect_v("sw_write_cycles", 32'd1);
        expect_v("sw_addr", 32'd0);
        expect_v("lw_v0", 32'h1234);
        expect_v("dmem0", 32'h1234);
        do_reset();
        wr_cnt = 0;
        run_halt(50);
        check_next(32'(wr_cnt));
        check_next(wr_addr);
        check_next(register_v0);
        check_next(dmem[0]);

        // beq taken: delay slot runs, the following instruction is skipped
        clear_imem();
        imem[0] = i_op(4, 0, 0, 2);
        imem[1] = i_op(9, 0, 2, 7);
        imem[2] = i_op(9, 0, 2, 9);
        imem[3] = JR_ZERO;
        expect_v("beq_v0", 32'd7);
        do_reset();
        run_halt(50);
        check_next(register_v0);

        // jal to a subroutine, jr $31 back; delay slot of final jr copies $31 into $v0
        clear_imem();
        imem[0] = j_op(3, RV + 32'd20);
        imem[2] = i_op(9, 2, 2, 3);
        imem[3] = JR_ZERO;
        imem[4] = r_op(31, 0, 2, 0, 'h21);
        imem[5] = i_op(9, 0, 2, 10);
        imem[6] = r_op(31, 0, 0, 0, 8);
        expect_v("jal_v0_after_return", 32'd13);
        expect_v("jal_ra", RV + 32'd8);
        expect_v("jal_active", 32'd0);
        do_reset();
        repeat (6) step();
        check_next(register_v0);
        run_halt(50);
        check_next(register_v0);
        check_next({31'h0, active});

        // asynchronous reset in the middle of a run
        load_lo_prog();
        expect_v("prereset_v0", 32'd5);
        expect_v("areset_pc", RV);
        expect_v("areset_v0", 32'd0);
        expect_v("areset_active", 32'd1);
        do_reset();
        repeat (3) step();
        check_next(register_v0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_next(instr_address);
        check_next(register_v0);
        check_next({31'h0, active});
        @(posedge clk);
        #1 reset = 1'b0;

        // clk_enable low freezes the PC, then execution resumes
        load_lo_prog();
        expect_v("freeze_pc", RV + 32'd4);
        expect_v("freeze_active", 32'd1);
        expect_v("resume_v0", 32'd5);
        do_reset();
        step();
        clk_enable = 1'b0;
        repeat (3) step();
        check_next(instr_address);
        check_next({31'h0, active});
        clk_enable = 1'b1;
        run_halt(50);
        check_next(register_v0);

        // signed compare, arithmetic shift, addu
        clear_imem();
        imem[0] = i_op(9, 0, 1, -8);
        imem[1] = i_op(9, 0, 3, 3);
        imem[2] = r_op(1, 3, 4, 0, 'h2A);
        imem[3] = r_op(0, 1, 5, 1, 3);
        imem[4] = r_op(4, 5, 2, 0, 'h21);
        imem[5] = JR_ZERO;
        expect_v("slt_sra_v0", 32'hFFFFFFFD);
        do_reset();
        run_halt(50);
        check_next(register_v0);

        // $0 stays zero; lui + zero-extended ori
        clear_imem();
        imem[0] = i_op(9, 0, 0, 5);
        imem[1] = i_op('hF, 0, 1, 'h8000);
        imem[2] = i_op('hD, 1, 2, 'hFFFF);
        imem[3] = r_op(2, 0, 2, 0, 'h21);
        imem[4] = JR_ZERO;
        expect_v("lui_ori_v0", 32'h8000FFFF);
        do_reset();
        run_halt(50);
        check_next(register_v0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
